// File: rtl/sata_txarb_if.sv
// Bundle of the requester-side and link-side signals around the TX arbiter.
// The "master" modport is the arbiter's view and "slave" is the view of the
// surrounding requesters and link.
interface sata_txarb_if;
  logic        i_link_ready;
  logic [1:0]  s_valid;
  logic [1:0]  s_ready;
  logic [63:0] s_data;
  logic [1:0]  s_last;
  logic [1:0]  s_success;
  logic [1:0]  s_failed;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic        i_success;
  logic        i_failed;

  modport master (
    input  i_link_ready, s_valid, s_data, s_last, m_ready, i_success, i_failed,
    output s_ready, s_success, s_failed, m_valid, m_data, m_last
  );

  modport slave (
    output i_link_ready, s_valid, s_data, s_last, m_ready, i_success, i_failed,
    input  s_ready, s_success, s_failed, m_valid, m_data, m_last
  );
endinterface

// File: rtl/sata_txarb.sv
// Two-requester round-robin arbiter in front of the SATA link TX stream.
// A granted FIS is passed through with zero latency, then the arbiter waits
// for R_OK / R_ERR (or a timeout) and reports the result as a one-cycle pulse.
//
// state | meaning
// IDLE  | no owner; grant on link ready and any request, once no result pulse is pending
// SEND  | grantee's words pass straight through to the link
// WAIT  | FIS sent, waiting for link response or timeout
// FLUSH | FIS aborted, remaining words of the grantee are discarded
module sata_txarb #(
  parameter int LGTIMEOUT = 20
) (
  input  logic          i_clk,
  input  logic          i_reset,
  sata_txarb_if.master  bus,
  output logic          o_busy,
  output logic          o_grant
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    WAIT  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 grant_q, grant_d;
  logic                 last_q, last_d;
  logic [LGTIMEOUT-1:0] cnt_q, cnt_d;
  logic [1:0]           succ_q, succ_d;
  logic [1:0]           fail_q, fail_d;

  logic                 sel_valid;
  logic                 sel_last;
  logic [31:0]          sel_data;
  logic [1:0]           gmask;
  logic                 pick;
  logic                 abort_send;
  logic                 pulse_pending;
  logic [LGTIMEOUT-1:0] cnt_inc;

  logic [1:0]           s_ready_c;
  logic                 m_valid_c;
  logic                 m_last_c;

  // Select the current grantee's stream and precompute shared terms.
  always_comb begin
    sel_valid     = bus.s_valid[grant_q];
    sel_last      = bus.s_last[grant_q];
    sel_data      = grant_q ? bus.s_data[63:32] : bus.s_data[31:0];
    gmask         = grant_q ? 2'b10 : 2'b01;
    abort_send    = !bus.i_link_ready || bus.i_failed;
    pulse_pending = (succ_q != 2'b00) || (fail_q != 2'b00);
    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    cnt_inc       = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    // Round-robin pick: a lone requester wins, a tie goes to the one not granted last.
    case (bus.s_valid)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last_q;
      default: pick = grant_q;
    endcase
  end

  // Next-state, stream steering and result-pulse decode.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    succ_d    = 2'b00;
    fail_d    = 2'b00;
    s_ready_c = 2'b00;
    m_valid_c = 1'b0;
    m_last_c  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.i_link_ready && (bus.s_valid != 2'b00) && !pulse_pending) begin
          grant_d = pick;
          last_d  = pick;
          state_d = SEND;
        end
      end

      SEND: begin
        s_ready_c = gmask & {2{bus.m_ready}};
        if (abort_send) begin
          // A word accepted in this cycle is dropped; if it was the last one
          // nothing is left to flush.
          fail_d = gmask;
          if (sel_valid && sel_last && bus.m_ready)
            state_d = IDLE;
          else
            state_d = FLUSH;
        end else begin
          m_valid_c = sel_valid;
          m_last_c  = sel_last;
          if (sel_valid && bus.m_ready && sel_last) begin
            cnt_d   = '0;
            state_d = WAIT;
          end
        end
      end

      WAIT: begin
        cnt_d = cnt_inc;
        // Failure (including link drop and timeout) beats a simultaneous R_OK.
        if (bus.i_failed || !bus.i_link_ready || (cnt_inc == '1)) begin
          fail_d  = gmask;
          state_d = IDLE;
        end else if (bus.i_success) begin
          succ_d  = gmask;
          state_d = IDLE;
        end
      end

      FLUSH: begin
        s_ready_c = gmask;
        if (sel_valid && sel_last)
          state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State, grant, timeout counter and result pulse registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      succ_q  <= 2'b00;
      fail_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      succ_q  <= succ_d;
      fail_q  <= fail_d;
    end
  end

  assign bus.s_ready   = s_ready_c;
  assign bus.m_valid   = m_valid_c;
  assign bus.m_last    = m_last_c;
  assign bus.m_data    = sel_data;
  assign bus.s_success = succ_q;
  assign bus.s_failed  = fail_q;
  assign o_busy        = (state_q != IDLE);
  assign o_grant       = grant_q;

endmodule

// File: doc/sata_txarb.md
SATA_TXARB -- requirements
Module: sata_txarb

Interface
REQ-001 SHALL have parameter LGTIMEOUT, default 20: width of the post-packet response timeout counter.
REQ-002 SHALL have port i_clk, input, 1: the single clock (link TX clock domain).
REQ-003 SHALL have port i_reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port i_link_ready, input, 1: link is synced, error-free and ready.
REQ-005 SHALL have port s_valid, input, 2: per-requester word valid (bit 0 = command FIS source, bit 1 = data FIS source).
REQ-006 SHALL have port s_ready, output, 2: per-requester word accepted.
REQ-007 SHALL have port s_data, input, 64: requester n word on bits [32n+31:32n].
REQ-008 SHALL have port s_last, input, 2: per-requester last word of FIS.
REQ-009 SHALL have port s_success, output, 2: one-cycle pulse meaning the requester's FIS was acknowledged.
REQ-010 SHALL have port s_failed, output, 2: one-cycle pulse meaning the requester's FIS failed.
REQ-011 SHALL have port m_valid, output, 1: word valid to the link TX stream.
REQ-012 SHALL have port m_ready, input, 1: link accepts the word.
REQ-013 SHALL have port m_data, output, 32: word to the link.
REQ-014 SHALL have port m_last, output, 1: last word to the link.
REQ-015 SHALL have port i_success, input, 1: link reports R_OK.
REQ-016 SHALL have port i_failed, input, 1: link reports R_ERR or abort.
REQ-017 SHALL have port o_busy, output, 1: state is not IDLE.
REQ-018 SHALL have port o_grant, output, 1: index of the current or most recent grantee.

Function
REQ-019 SHALL implement the states IDLE, SEND, WAIT and FLUSH.
REQ-020 IDLE: when i_link_ready and s_valid!=0, SHALL grant and move to SEND on the next cycle.
REQ-021 Grant selection SHALL be round-robin: a lone requester wins; on a tie, the requester not granted last wins.
REQ-022 SEND: m_valid, m_data and m_last SHALL equal s_valid[g], s_data[g] and s_last[g] combinationally, where g = o_grant.
REQ-023 SEND: s_ready[g] SHALL equal m_ready; the non-granted s_ready bit SHALL be 0; latency through the block is zero cycles.
REQ-024 SEND: on m_valid&&m_ready&&m_last, SHALL move to WAIT and clear the timeout counter.
REQ-025 WAIT: m_valid SHALL be 0 and s_ready SHALL be 0; the counter SHALL increment once per cycle.
REQ-026 WAIT: on i_success, SHALL pulse s_success[g] on the next cycle and go to IDLE.
REQ-027 WAIT: on i_failed, SHALL pulse s_failed[g] and go to IDLE.
REQ-028 WAIT: if i_success and i_failed occur together, failure SHALL win.
REQ-029 WAIT: when the counter reaches all-ones (2^LGTIMEOUT-1 cycles), SHALL pulse s_failed[g] and go to IDLE.
REQ-030 SEND: if i_link_ready drops or i_failed asserts, SHALL pulse s_failed[g], force m_valid=0, and go to FLUSH.
REQ-031 SEND: a failure on the same cycle as the last-word handshake SHALL take precedence and go to IDLE, since no words remain.
REQ-032 FLUSH: s_ready[g] SHALL be 1 and m_valid SHALL be 0 (words discarded); on s_valid[g]&&s_last[g], SHALL go to IDLE.
REQ-033 In IDLE and SEND, i_success SHALL be ignored.
REQ-034 In WAIT, a drop of i_link_ready SHALL behave as i_failed.
REQ-035 s_success and s_failed SHALL be registered, one cycle wide, and never both set in the same cycle.
REQ-036 A new grant SHALL NOT occur in the same cycle that a result pulse is asserted (at least one IDLE cycle).
REQ-037 The counter SHALL saturate and never wrap.

Reset
REQ-038 On i_reset, state SHALL be IDLE, o_grant 0, last-granted 1 (requester 0 wins the first tie), counter 0.
REQ-039 On i_reset, s_ready, s_success, s_failed, m_valid and o_busy SHALL be 0.
REQ-040 A reset asserted mid-SEND or mid-WAIT SHALL take effect on the next edge with no result pulse emitted.

Verification
REQ-041 Both requesters valid with 3-word FIS each, m_ready=1, i_success 5 cycles after each last -> requester 0 sends first, s_success=2'b01, then requester 1, s_success=2'b10.
REQ-042 Requester 1 alone, m_ready toggling 1/0, words 0xA0000001..0xA0000004 -> m_data order preserved, s_ready[1] mirrors m_ready, s_ready[0]=0 throughout.
REQ-043 LGTIMEOUT=4, no response after last -> s_failed[g] pulses 15 cycles after entering WAIT, o_busy then falls.
REQ-044 i_link_ready dropped after word 2 of 5 -> s_failed pulse, FLUSH consumes words 3-5 with m_valid=0, then IDLE.
REQ-045 i_success and i_failed asserted on the same WAIT cycle -> only s_failed pulses.
REQ-046 i_reset asserted during WAIT -> next cycle o_busy=0 and no s_success/s_failed pulse.
